stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes and one registered output stage.
- Next generation of the combinational 4:1 bit mux: generalised width and channel count.
- Adds a round-robin arbitration mode alongside explicit-select mode.
- Sits between several producer streams and a single consumer, e.g. merging request channels into one bus port.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SW, clog2(N) (min 1), width of the selector and channel-id fields; derived, not overridable.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- io_mode  input  1  0 = round-robin arbitration, 1 = fixed select via io_selector.
- io_selector  input  SW  channel index used in fixed mode; ignored in round-robin mode.
- io_in_valid  input  N  per-channel valid, bit i = channel i.
- io_in_ready  output  N  per-channel ready, at most one bit high (one-hot or zero).
- io_in_data  input  N*W  channel i data at bits [i*W+W-1 : i*W].
- io_out_valid  output  1  output register holds a beat.
- io_out_ready  input  1  consumer accepts the beat.
- io_out_data  output  W  registered data.
- io_out_chan  output  SW  index of the channel that produced io_out_data.

Behaviour:
- Reset (async assert, synchronous release): io_out_valid=0, io_out_data=0, io_out_chan=0, rr pointer=0.
- While reset is high, io_in_ready=0.
- Stage ready: stage_rdy = !io_out_valid | io_out_ready. This is a pipeline-ready register; full throughput of 1 beat/cycle is required.
- Grant g is combinational from io_in_valid, io_mode, io_selector and the pointer.
- io_in_ready[g] = stage_rdy & grant_valid; all other io_in_ready bits are 0.
- Input transfer on channel g when io_in_valid[g] & io_in_ready[g].
- Round-robin mode: scan indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Grant the first index with io_in_valid set. No valid bits means no grant.
- After each input transfer in round-robin mode, ptr <= (g+1) mod N.
- ptr is unchanged when there is no transfer or when in fixed mode.
- Fixed mode: grant = io_selector if io_selector < N and io_in_valid[io_selector]; otherwise no grant. An out-of-range selector (N not a power of 2) never grants and never stalls other logic.
- On an input transfer: io_out_data <= channel g data, io_out_chan <= g, io_out_valid <= 1. Latency is exactly 1 cycle from input handshake to io_out_valid.
- If io_out_valid & io_out_ready and there is no input transfer: io_out_valid <= 0, io_out_data and io_out_chan hold their values.
- Simultaneous output drain and input transfer: new beat is loaded and io_out_valid stays 1, with no bubble.
- io_out_valid & !io_out_ready: the register holds, io_in_ready = 0 on all channels, and ptr does not move.
- Mode or selector changes take effect in the same cycle. A beat already in the output register is unaffected.
- Input data is not required to be stable while not granted.

Decomposition:
- Shared package:
  - MODE_RR = 0, MODE_FIXED = 1.
  - clog2 helper function.
  - SW derivation, so other multi-channel blocks reuse it.
- One sub-module, rr_arbiter (parameter N).
  - Inputs: req[N], ptr[SW].
  - Outputs: gnt_valid, gnt_idx[SW]. Purely combinational rotate-priority encoder.
- Pointer register, fixed-mode selection and output register live in stream_mux_rr.

Test Plan:
- Reset with N=4, W=8, all io_in_valid=4'b1111, io_out_ready=1, mode RR. Grants follow 0,1,2,3,0. io_out_chan sequence 0,1,2,3,0 on consecutive cycles starting 1 cycle after first grant; io_out_valid held at 1 throughout.
- RR with io_in_valid=4'b1010 held, data ch1=0x11, ch3=0x33. Outputs alternate 0x11/0x33 with chan 1/3; channels 0 and 2 never get ready.
- Backpressure: one beat loaded (0x5A from ch2), then io_out_ready=0 for 3 cycles. io_out_data stays 0x5A, all io_in_ready=0, ptr stays 3. On release, the next beat is loaded in the same cycle as the drain.
- Fixed mode, io_selector=2, io_in_valid=4'b0111. Only ch2 is granted every cycle. With io_selector=2 and io_in_valid=4'b1011, no grant occurs, io_out_valid falls after drain, and ptr is unchanged.
- N=3: fixed mode with io_selector=3 produces no grant and io_in_ready=0. Switching to RR mid-stream resumes from the saved ptr; RR wraps 2→0.
- Assert reset asynchronously mid-stream with io_out_valid=1. io_out_valid, io_out_data and io_out_chan go to 0 before the next clock edge. After release, the first RR grant is ch0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for multi-channel stream blocks: mode encodings and
// the selector / channel-id width derivation.
package stream_mux_rr_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Selector width never collapses to zero bits, even for a single channel.
    function automatic int sel_width(input int n);
        return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority encoder: grants the requester closest to
// ptr when walking upward with wrap-around.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_valid,
    output logic [SW-1:0] gnt_idx
);

    int  dist_s;
    int  best_dist_s;
    logic take_s;

    // Pick the requester with the smallest rotated distance from ptr.
    always_comb begin
        gnt_valid   = 1'b0;
        gnt_idx     = {SW{1'b0}};
        best_dist_s = 32'sd0;
        dist_s      = 32'sd0;
        take_s      = 1'b0;
        for (int i = 0; i < N; i++) begin
            dist_s      = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            take_s      = req[i] & (~gnt_valid | (dist_s < best_dist_s));
            best_dist_s = take_s ? dist_s : best_dist_s;
            gnt_idx     = take_s ? SW'(i) : gnt_idx;
            gnt_valid   = gnt_valid | req[i];
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration feeding a single registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = sel_width(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           io_mode,
    input  logic [SW-1:0]  io_selector,
    input  logic [N-1:0]   io_in_valid,
    output logic [N-1:0]   io_in_ready,
    input  logic [N*W-1:0] io_in_data,
    output logic           io_out_valid,
    input  logic           io_out_ready,
    output logic [W-1:0]   io_out_data,
    output logic [SW-1:0]  io_out_chan
);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_chan_q,  out_chan_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    logic          rr_gnt_valid_s;
    logic [SW-1:0] rr_gnt_idx_s;
    logic          fix_gnt_valid_s;
    logic          gnt_valid_s;
    logic [SW-1:0] gnt_idx_s;
    logic [W-1:0]  gnt_data_s;
    logic          stage_rdy_s;
    logic          xfer_s;

    rr_arbiter #(.N(N)) u_arb (
        .req       (io_in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_gnt_valid_s),
        .gnt_idx   (rr_gnt_idx_s)
    );

    // Fixed-mode request check; an out-of-range selector matches no channel.
    always_comb begin
        fix_gnt_valid_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            fix_gnt_valid_s = fix_gnt_valid_s | ((io_selector == SW'(i)) & io_in_valid[i]);
        end
    end

    // Grant source follows the current mode.
    always_comb begin
        if (io_mode == MODE_FIXED) begin
            gnt_valid_s = fix_gnt_valid_s;
            gnt_idx_s   = io_selector;
        end else begin
            gnt_valid_s = rr_gnt_valid_s;
            gnt_idx_s   = rr_gnt_idx_s;
        end
    end

    assign stage_rdy_s = ~out_valid_q | io_out_ready;
    assign xfer_s      = gnt_valid_s & stage_rdy_s & ~reset;

    // Ready is driven only toward the granted channel; data mux for the winner.
    always_comb begin
        io_in_ready = {N{1'b0}};
        gnt_data_s  = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            io_in_ready[i] = xfer_s & (gnt_idx_s == SW'(i));
            gnt_data_s     = (gnt_idx_s == SW'(i)) ? io_in_data[i*W +: W] : gnt_data_s;
        end
    end

    // Output stage and pointer next-state; load and drain may coincide.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data_s;
            out_chan_d  = gnt_idx_s;
            if (io_mode == MODE_RR) begin
                ptr_d = (gnt_idx_s == SW'(N - 1)) ? {SW{1'b0}} : (gnt_idx_s + SW'(1));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (io_out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_chan_q  <= {SW{1'b0}};
            ptr_q       <= {SW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_data  = out_data_q;
    assign io_out_chan  = out_chan_q;

endmodule
